// File: rtl/corereset_pf_pkg.sv
// rtl/corereset_pf_pkg.sv - shared state enum and default constants for corereset_pf
package corereset_pf_pkg;

   // Release sequencer states: reset held, clean-cycle counting, released
   typedef enum logic [1:0] {
      ASSERT = 2'd0,
      COUNT  = 2'd1,
      RUN    = 2'd2
   } state_e;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_DEASSERT_DELAY = 16;

   // Counter must hold DEASSERT_DELAY-1 with headroom so it can never wrap
   function automatic int cnt_width(input int delay);
      return $clog2(delay) + 1;
   endfunction

endpackage

// File: rtl/corereset_sync.sv
// rtl/corereset_sync.sv - single-bit multi-flop synchronizer with configurable reset value
module corereset_sync #(
   parameter int   DEPTH     = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain_q;
   logic [DEPTH-1:0] chain_d;

   // Shift the asynchronous input one stage deeper each cycle
   always_comb begin
      chain_d = {chain_q[DEPTH-2:0], d};
   end

   // Chain resets to the requesting level so reset is held until inputs prove clean
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= {DEPTH{RESET_VAL}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/corereset_pf.sv
// rtl/corereset_pf.sv - fabric reset sequencer: synchronize requests, count clean cycles, release
module corereset_pf
   import corereset_pf_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int DEASSERT_DELAY = DEF_DEASSERT_DELAY
) (
   input  logic CLK,
   input  logic RST,
   input  logic EXT_RST_N,
   input  logic PLL_LOCK,
   input  logic SS_BUSY,
   input  logic INIT_DONE,
   input  logic FF_US_RESTORE,
   output logic FABRIC_RESET_N
);

   localparam int                CNT_W    = cnt_width(DEASSERT_DELAY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEASSERT_DELAY - 1);

   logic ext_rst_n_s;
   logic pll_lock_s;
   logic ss_busy_s;
   logic init_done_s;
   logic ff_us_restore_s;
   logic req;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fabric_reset_n_q, fabric_reset_n_d;

   corereset_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ext_rst_n (
      .clk (CLK), .rst (RST), .d (EXT_RST_N), .q (ext_rst_n_s)
   );

   corereset_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pll_lock (
      .clk (CLK), .rst (RST), .d (PLL_LOCK), .q (pll_lock_s)
   );

   corereset_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_init_done (
      .clk (CLK), .rst (RST), .d (INIT_DONE), .q (init_done_s)
   );

   corereset_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_busy (
      .clk (CLK), .rst (RST), .d (SS_BUSY), .q (ss_busy_s)
   );

   corereset_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ff_us_restore (
      .clk (CLK), .rst (RST), .d (FF_US_RESTORE), .q (ff_us_restore_s)
   );

   assign req = !ext_rst_n_s | !pll_lock_s | !init_done_s | ss_busy_s | ff_us_restore_s;

   // Next state and counter: any request drops back to ASSERT, release after a full clean count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ASSERT: begin
            cnt_d = '0;
            if (!req) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (req) begin
               state_d = ASSERT;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            cnt_d = '0;
            if (req) begin
               state_d = ASSERT;
            end
         end
         default: begin
            state_d = ASSERT;
            cnt_d   = '0;
         end
      endcase
      fabric_reset_n_d = (state_d == RUN);
   end

   // State, counter and registered glitch-free output; RST wins on the same edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q          <= ASSERT;
         cnt_q            <= '0;
         fabric_reset_n_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         fabric_reset_n_q <= fabric_reset_n_d;
      end
   end

   assign FABRIC_RESET_N = fabric_reset_n_q;

endmodule

// File: tb/tb_corereset_pf.sv
// tb/tb_corereset_pf.sv - scoreboard bench for corereset_pf release/assert timing
module tb_corereset_pf;

   localparam int S          = 2;
   localparam int D          = 16;
   localparam int ASSERT_LAT = S + 1;
   localparam int REL_LAT    = S + D + 1;

   logic CLK           = 1'b0;
   logic RST           = 1'b1;
   logic EXT_RST_N     = 1'b1;
   logic PLL_LOCK      = 1'b1;
   logic SS_BUSY       = 1'b0;
   logic INIT_DONE     = 1'b1;
   logic FF_US_RESTORE = 1'b0;
   logic FABRIC_RESET_N;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   typedef struct {
      string tag;
      int    edge_n;
      logic  val;
   } exp_t;

   exp_t sb[$];
   logic prev_n = 1'b0;

   corereset_pf #(.SYNC_STAGES(S), .DEASSERT_DELAY(D)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .EXT_RST_N      (EXT_RST_N),
      .PLL_LOCK       (PLL_LOCK),
      .SS_BUSY        (SS_BUSY),
      .INIT_DONE      (INIT_DONE),
      .FF_US_RESTORE  (FF_US_RESTORE),
      .FABRIC_RESET_N (FABRIC_RESET_N)
   );

   always #50 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Every output transition must match the next expected event in value and edge number
   always @(negedge CLK) begin
      exp_t e;
      if (FABRIC_RESET_N !== prev_n) begin
         if (sb.size() == 0) begin
            chk("spurious_edge", FABRIC_RESET_N, prev_n);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_val"}, FABRIC_RESET_N, e.val);
            chk({e.tag, "_edge"}, cyc, e.edge_n);
         end
         prev_n = FABRIC_RESET_N;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic expect_edge(input string tag, input int lat, input logic val);
      exp_t e;
      e.tag    = tag;
      e.edge_n = cyc + lat;
      e.val    = val;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag, input int budget);
      int t;
      t = 0;
      while (sb.size() != 0 && t < budget) begin
         @(negedge CLK);
         t++;
      end
      step(1);
      chk({tag, "_drained"}, sb.size(), 0);
   endtask

   task automatic set_src(input int i, input logic v);
      case (i)
         0:       EXT_RST_N = v;
         1:       PLL_LOCK  = v;
         default: INIT_DONE = v;
      endcase
   endtask

   initial begin
      #(100 * 20000);
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1);
   end

   initial begin
      // Power-on: reset held, then release with all inputs idle-good
      RST = 1'b1;
      step(4);
      chk("rst_state", FABRIC_RESET_N, 0);
      RST = 1'b0;
      expect_edge("por_release", REL_LAT, 1'b1);
      step(REL_LAT - 2);
      chk("no_early_release", FABRIC_RESET_N, 0);
      drain("por", 40);
      chk("run_state", FABRIC_RESET_N, 1);

      // Each active-low source drops, busy/restore pulse on top, then everything clears
      for (int i = 0; i < 3; i++) begin
         step(3);
         set_src(i, 1'b0);
         expect_edge($sformatf("src%0d_assert", i), ASSERT_LAT, 1'b0);
         step(1); SS_BUSY = 1'b1;
         step(1); FF_US_RESTORE = 1'b1;
         step(1); SS_BUSY = 1'b0;
         step(1); FF_US_RESTORE = 1'b0;
         step(4);
         set_src(i, 1'b1);
         expect_edge($sformatf("src%0d_release", i), REL_LAT, 1'b1);
         drain($sformatf("src%0d", i), 40);
      end

      // Overlapping requests: release follows the last one to clear
      step(2);
      EXT_RST_N = 1'b0;
      expect_edge("ovl_assert", ASSERT_LAT, 1'b0);
      step(4); PLL_LOCK = 1'b0;
      step(4); EXT_RST_N = 1'b1;
      step(6); PLL_LOCK = 1'b1;
      expect_edge("ovl_release", REL_LAT, 1'b1);
      drain("ovl", 40);

      // Restore pulse while counting at 10 restarts the full count
      step(2);
      EXT_RST_N = 1'b0;
      expect_edge("pulse_assert", ASSERT_LAT, 1'b0);
      step(5); EXT_RST_N = 1'b1;
      step(10); FF_US_RESTORE = 1'b1;
      step(1); FF_US_RESTORE = 1'b0;
      expect_edge("pulse_release", REL_LAT, 1'b1);
      drain("pulse", 50);

      // Busy held indefinitely keeps reset asserted
      step(2);
      SS_BUSY = 1'b1;
      expect_edge("busy_assert", ASSERT_LAT, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(20);
         chk("busy_hold", FABRIC_RESET_N, 0);
      end
      SS_BUSY = 1'b0;
      expect_edge("busy_release", REL_LAT, 1'b1);
      drain("busy", 40);

      // One-cycle request pulse still asserts, then releases from its clear point
      step(2);
      INIT_DONE = 1'b0;
      expect_edge("short_assert", ASSERT_LAT, 1'b0);
      step(1); INIT_DONE = 1'b1;
      expect_edge("short_release", REL_LAT, 1'b1);
      drain("short", 40);

      // RST in RUN drops the output on the same edge
      step(2);
      RST = 1'b1;
      expect_edge("rst_run_assert", 1, 1'b0);
      step(3);
      chk("rst_run_hold", FABRIC_RESET_N, 0);
      RST = 1'b0;
      expect_edge("rst_run_release", REL_LAT, 1'b1);
      drain("rst_run", 40);

      // RST mid-count restarts the full sequence
      step(2);
      EXT_RST_N = 1'b0;
      expect_edge("rst_cnt_assert", ASSERT_LAT, 1'b0);
      step(5); EXT_RST_N = 1'b1;
      step(8); RST = 1'b1;
      step(2); RST = 1'b0;
      expect_edge("rst_cnt_release", REL_LAT, 1'b1);
      drain("rst_cnt", 40);

      step(5);
      chk("sb_empty", sb.size(), 0);
      chk("final_run", FABRIC_RESET_N, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
